// File: rtl/ap_accum.sv
// Multi-lane MAC accumulator: sums N_cell products per lane over several input passes,
// then applies bias/round/saturate/ReLU and an optional 1-D max-pool before a valid/ready output.
module ap_accum #(
  parameter int cell_bit = 8,
  parameter int N_cell   = 9,
  parameter int biasport = 16,
  parameter int N_core   = 8,
  parameter int outport  = 8,
  parameter int acc_bit  = 32,
  parameter int pass_bit = 4,
  parameter int mp_bit   = 2
) (
  input  logic                                clk,
  input  logic                                reset,
  input  logic [cell_bit*N_cell-1:0]          in,
  input  logic [cell_bit*N_cell*N_core-1:0]   weight,
  input  logic [biasport*N_core-1:0]          bias,
  input  logic [2:0]                          bound_level,
  input  logic [pass_bit-1:0]                 n_pass,
  input  logic                                en,
  output logic                                in_ready,
  input  logic                                en_relu,
  input  logic                                en_mp,
  input  logic [mp_bit-1:0]                   mp_len,
  output logic [outport*N_core-1:0]           out,
  output logic                                out_valid,
  input  logic                                out_ready,
  output logic                                busy
);

  localparam int WIN  = cell_bit * N_cell;
  localparam int WTOT = WIN * N_core;
  localparam int BTOT = biasport * N_core;
  localparam int OTOT = outport * N_core;
  localparam logic signed [acc_bit-1:0] SAT_MAX = acc_bit'((2 ** (outport - 1)) - 1);
  localparam logic signed [acc_bit-1:0] SAT_MIN = acc_bit'(-(2 ** (outport - 1)));

  typedef enum logic [1:0] {ACC, POST, HOLD} state_t;

  state_t state, state_nxt;

  logic [pass_bit-1:0] pcnt, cfg_np, eff_np;
  logic [mp_bit-1:0]   mcnt, cfg_mp_len;
  logic [2:0]          cfg_bound;
  logic                cfg_relu, cfg_mp;
  logic                beat, group_start, last_pass, pool_done;

  logic signed [acc_bit-1:0]      acc   [N_core];
  logic signed [acc_bit-1:0]      dot   [N_core];
  logic signed [outport-1:0]      pmax  [N_core];
  logic signed [outport-1:0]      y     [N_core];
  logic signed [outport-1:0]      pnext [N_core];
  logic signed [2*cell_bit-1:0]   prod;
  logic signed [acc_bit-1:0]      rnd, rsum, rsh;

  assign in_ready    = (state == ACC) && !reset;
  assign beat        = en && in_ready;
  assign group_start = (pcnt == '0) && (mcnt == '0);
  // The first beat of a group must already obey the n_pass presented with it.
  assign eff_np      = group_start ? n_pass : cfg_np;
  assign last_pass   = (pcnt == eff_np);
  assign pool_done   = !cfg_mp || (mcnt == cfg_mp_len);
  assign busy        = (pcnt != '0) || (mcnt != '0) || (state != ACC);

  always_comb begin
    prod = '0;
    for (int i = 0; i < N_core; i++) begin
      dot[i] = '0;
      for (int k = 0; k < N_cell; k++) begin
        prod   = $signed(in[WIN-1-k*cell_bit -: cell_bit]) *
                 $signed(weight[WTOT-1-i*WIN-k*cell_bit -: cell_bit]);
        dot[i] = dot[i] + acc_bit'(prod);
      end
    end
  end

  // Round half up, shift, saturate only after the shift, then optional ReLU and pool max.
  always_comb begin
    rnd  = '0;
    rsum = '0;
    rsh  = '0;
    if (cfg_bound != 3'd0) rnd[cfg_bound - 3'd1] = 1'b1;
    for (int i = 0; i < N_core; i++) begin
      rsum = acc[i] + rnd;
      rsh  = rsum >>> cfg_bound;
      if (rsh > SAT_MAX)      y[i] = outport'(SAT_MAX);
      else if (rsh < SAT_MIN) y[i] = outport'(SAT_MIN);
      else                    y[i] = outport'(rsh);
      if (cfg_relu && y[i][outport-1]) y[i] = '0;
      pnext[i] = ((mcnt == '0) || (y[i] > pmax[i])) ? y[i] : pmax[i];
    end
  end

  always_comb begin
    state_nxt = state;
    unique case (state)
      ACC:     if (beat && last_pass) state_nxt = POST;
      POST:    state_nxt = pool_done ? HOLD : ACC;
      HOLD:    if (out_ready) state_nxt = ACC;
      default: state_nxt = ACC;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) state <= ACC;
    else       state <= state_nxt;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      pcnt       <= '0;
      mcnt       <= '0;
      cfg_np     <= '0;
      cfg_mp_len <= '0;
      cfg_bound  <= '0;
      cfg_relu   <= 1'b0;
      cfg_mp     <= 1'b0;
      out        <= '0;
      out_valid  <= 1'b0;
      for (int i = 0; i < N_core; i++) begin
        acc[i]  <= '0;
        pmax[i] <= '0;
      end
    end else begin
      unique case (state)
        ACC: if (beat) begin
          if (group_start) begin
            cfg_np     <= n_pass;
            cfg_bound  <= bound_level;
            cfg_relu   <= en_relu;
            cfg_mp     <= en_mp;
            cfg_mp_len <= mp_len;
          end
          pcnt <= last_pass ? '0 : pcnt + pass_bit'(1);
          for (int i = 0; i < N_core; i++) begin
            if (pcnt == '0)
              acc[i] <= acc_bit'($signed(bias[BTOT-1-i*biasport -: biasport])) + dot[i];
            else
              acc[i] <= acc[i] + dot[i];
          end
        end
        POST: begin
          if (cfg_mp) begin
            for (int i = 0; i < N_core; i++) pmax[i] <= pnext[i];
          end
          if (pool_done) begin
            for (int i = 0; i < N_core; i++)
              out[OTOT-1-i*outport -: outport] <= cfg_mp ? pnext[i] : y[i];
            out_valid <= 1'b1;
            mcnt      <= '0;
          end else begin
            mcnt <= mcnt + mp_bit'(1);
          end
        end
        HOLD: if (out_ready) out_valid <= 1'b0;
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_ap_accum.sv
// Directed bench for ap_accum: table of single-group vectors plus hand-written
// max-pool, backpressure, config-latching and reset sequences.
module tb_ap_accum;

  localparam int NC = 8;

  typedef struct {
    logic signed [7:0]  a;
    logic signed [7:0]  w;
    logic signed [15:0] b;
    logic signed [15:0] bstep;
    logic [2:0]         bl;
    logic [3:0]         np;
    logic               relu;
    logic signed [7:0]  exp_base;
    logic signed [7:0]  exp_step;
  } vec_t;

  logic         clk = 1'b0;
  logic         reset;
  logic [71:0]  in_win;
  logic [575:0] weight;
  logic [127:0] bias_vec;
  logic [2:0]   bound_level;
  logic [3:0]   n_pass;
  logic         en;
  logic         in_ready;
  logic         en_relu;
  logic         en_mp;
  logic [1:0]   mp_len;
  logic [63:0]  out_vec;
  logic         out_valid;
  logic         out_ready;
  logic         busy;

  int   n_checks = 0;
  int   n_fail   = 0;
  int   cyc;
  vec_t vecs [14];

  always #5 clk = ~clk;

  ap_accum dut (
    .clk(clk), .reset(reset), .in(in_win), .weight(weight), .bias(bias_vec),
    .bound_level(bound_level), .n_pass(n_pass), .en(en), .in_ready(in_ready),
    .en_relu(en_relu), .en_mp(en_mp), .mp_len(mp_len), .out(out_vec),
    .out_valid(out_valid), .out_ready(out_ready), .busy(busy)
  );

  task automatic checkOutput(input string name, input logic [63:0] actual, input logic [63:0] expected);
    n_checks++;
    if (actual !== expected) begin
      n_fail++;
      $display("[TB] FAIL %s: got %h, expected %h", name, actual, expected);
    end
  endtask

  function automatic logic [63:0] exp_pack(input logic signed [7:0] base, input logic signed [7:0] step);
    logic [63:0] r;
    for (int i = 0; i < NC; i++) r[63-8*i -: 8] = base + 8'(step * i);
    return r;
  endfunction

  task automatic set_data(input logic signed [7:0] a, input logic signed [7:0] w,
                          input logic signed [15:0] b, input logic signed [15:0] bstep);
    in_win = {9{a}};
    weight = {72{w}};
    for (int i = 0; i < NC; i++) bias_vec[127-16*i -: 16] = b + 16'(bstep * i);
  endtask

  task automatic wait_valid(output int cycles);
    cycles = 0;
    while (out_valid !== 1'b1 && cycles < 50) begin
      @(posedge clk); #1;
      cycles++;
    end
  endtask

  task automatic release_result(input string name);
    out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
    checkOutput({name, "_valid_drop"}, 64'(out_valid), 64'd0);
    checkOutput({name, "_in_ready_back"}, 64'(in_ready), 64'd1);
  endtask

  // Drive one full group and check latency and lane results; the result is left in HOLD.
  task automatic applyStimulus(input vec_t v, input string name);
    int c;
    set_data(v.a, v.w, v.b, v.bstep);
    bound_level = v.bl;
    n_pass      = v.np;
    en_relu     = v.relu;
    en_mp       = 1'b0;
    en          = 1'b1;
    for (int p = 0; p <= int'(v.np); p++) begin
      @(posedge clk); #1;
    end
    en = 1'b0;
    wait_valid(c);
    checkOutput({name, "_latency"}, 64'(c), 64'd1);
    checkOutput({name, "_out"}, out_vec, exp_pack(v.exp_base, v.exp_step));
  endtask

  initial begin
    #500000;
    $display("[TB] FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "[TB] watchdog");
  end

  initial begin
    vecs[0]  = '{8'sd1,    8'sd2,    16'sd10,   16'sd0,   3'd2, 4'd2, 1'b0, 8'sd16,   8'sd0};
    vecs[1]  = '{8'sd127,  8'sd127,  16'sd0,    16'sd0,   3'd0, 4'd0, 1'b0, 8'sd127,  8'sd0};
    vecs[2]  = '{8'sd127, -8'sd127,  16'sd0,    16'sd0,   3'd0, 4'd0, 1'b0, -8'sd128, 8'sd0};
    vecs[3]  = '{8'sd127, -8'sd127,  16'sd0,    16'sd0,   3'd0, 4'd0, 1'b1, 8'sd0,    8'sd0};
    vecs[4]  = '{8'sd0,    8'sd0,    16'sd6,    16'sd0,   3'd2, 4'd0, 1'b0, 8'sd2,    8'sd0};
    vecs[5]  = '{8'sd0,    8'sd0,   -16'sd6,    16'sd0,   3'd2, 4'd0, 1'b0, -8'sd1,   8'sd0};
    vecs[6]  = '{8'sd1,    8'sd1,   -16'sd20,   16'sd4,   3'd1, 4'd1, 1'b0, -8'sd1,   8'sd2};
    vecs[7]  = '{8'sd2,   -8'sd3,    16'sd0,    16'sd0,   3'd3, 4'd3, 1'b0, -8'sd27,  8'sd0};
    vecs[8]  = '{8'sd2,   -8'sd3,    16'sd0,    16'sd0,   3'd3, 4'd3, 1'b1, 8'sd0,    8'sd0};
    vecs[9]  = '{8'sd0,    8'sd0,    16'sh8000, 16'sd0,   3'd7, 4'd0, 1'b0, -8'sd128, 8'sd0};
    vecs[10] = '{8'sd0,    8'sd0,    16'sd32767, 16'sd0,  3'd7, 4'd0, 1'b0, 8'sd127,  8'sd0};
    vecs[11] = '{8'sd0,    8'sd0,    16'sd128,  16'sd0,   3'd0, 4'd0, 1'b0, 8'sd127,  8'sd0};
    vecs[12] = '{8'sd0,    8'sd0,   -16'sd129,  16'sd0,   3'd0, 4'd0, 1'b0, -8'sd128, 8'sd0};
    vecs[13] = '{8'sd0,    8'sd0,    16'sd127, -16'sd1,   3'd0, 4'd0, 1'b0, 8'sd127, -8'sd1};

    reset = 1'b1; en = 1'b0; out_ready = 1'b0; en_relu = 1'b0; en_mp = 1'b0;
    mp_len = 2'd0; n_pass = 4'd0; bound_level = 3'd0;
    set_data(8'sd0, 8'sd0, 16'sd0, 16'sd0);
    repeat (2) @(posedge clk);
    #1;
    checkOutput("reset_out", out_vec, 64'd0);
    checkOutput("reset_valid", 64'(out_valid), 64'd0);
    checkOutput("reset_busy", 64'(busy), 64'd0);
    checkOutput("reset_in_ready", 64'(in_ready), 64'd0);
    reset = 1'b0;
    #1;
    checkOutput("post_reset_in_ready", 64'(in_ready), 64'd1);

    for (int v = 0; v < 14; v++) begin
      applyStimulus(vecs[v], $sformatf("vec%0d", v));
      release_result($sformatf("vec%0d", v));
    end

    // Max-pool over four single-pass results 5,-3,9,2 (lane i offset by +i).
    $display("[TB] max-pool sequence");
    en_mp = 1'b1; mp_len = 2'd3; n_pass = 4'd0; bound_level = 3'd0; en_relu = 1'b0;
    begin
      logic signed [15:0] res [4];
      res[0] = 16'sd5; res[1] = -16'sd3; res[2] = 16'sd9; res[3] = 16'sd2;
      for (int j = 0; j < 4; j++) begin
        set_data(8'sd0, 8'sd0, res[j], 16'sd1);
        en = 1'b1;
        @(posedge clk); #1;
        en = 1'b0;
        if (j < 3) begin
          @(posedge clk); #1;
          checkOutput($sformatf("pool_no_valid%0d", j), 64'(out_valid), 64'd0);
          checkOutput($sformatf("pool_busy%0d", j), 64'(busy), 64'd1);
        end
      end
    end
    wait_valid(cyc);
    checkOutput("pool_latency", 64'(cyc), 64'd1);
    checkOutput("pool_out", out_vec, exp_pack(8'sd9, 8'sd1));
    en_mp = 1'b0;
    release_result("pool");
    checkOutput("pool_busy_clear", 64'(busy), 64'd0);

    // Backpressure: result must hold and no beat may slip in.
    $display("[TB] backpressure sequence");
    applyStimulus(vecs[0], "bp");
    en = 1'b1;
    for (int k = 0; k < 5; k++) begin
      @(posedge clk); #1;
      checkOutput($sformatf("bp_out_stable%0d", k), out_vec, exp_pack(8'sd16, 8'sd0));
      checkOutput($sformatf("bp_valid%0d", k), 64'(out_valid), 64'd1);
      checkOutput($sformatf("bp_in_ready%0d", k), 64'(in_ready), 64'd0);
    end
    en = 1'b0;
    release_result("bp");
    checkOutput("bp_busy", 64'(busy), 64'd0);
    applyStimulus(vecs[0], "bp_next");
    release_result("bp_next");

    // n_pass changed mid-group is ignored until the next group.
    $display("[TB] mid-group config change");
    set_data(8'sd1, 8'sd2, 16'sd10, 16'sd0);
    bound_level = 3'd2; en_relu = 1'b0; n_pass = 4'd2; en = 1'b1;
    @(posedge clk); #1;
    n_pass = 4'd0;
    for (int k = 0; k < 2; k++) begin
      checkOutput($sformatf("cfg_no_valid%0d", k), 64'(out_valid), 64'd0);
      @(posedge clk); #1;
    end
    en = 1'b0;
    wait_valid(cyc);
    checkOutput("cfg_latency", 64'(cyc), 64'd1);
    checkOutput("cfg_out", out_vec, exp_pack(8'sd16, 8'sd0));
    release_result("cfg");

    // Reset after the 2nd of 3 beats discards the partial group.
    $display("[TB] reset mid-group");
    set_data(8'sd1, 8'sd2, 16'sd10, 16'sd0);
    n_pass = 4'd2; en = 1'b1;
    repeat (2) begin @(posedge clk); #1; end
    en = 1'b0; reset = 1'b1;
    #1;
    checkOutput("rst_in_ready_low", 64'(in_ready), 64'd0);
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_mid_out", out_vec, 64'd0);
    checkOutput("rst_mid_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_mid_busy", 64'(busy), 64'd0);
    applyStimulus(vecs[0], "rst_after");
    release_result("rst_after");

    // Reset while a result waits in HOLD.
    $display("[TB] reset during hold");
    applyStimulus(vecs[1], "rst_hold_pre");
    reset = 1'b1;
    @(posedge clk); #1;
    reset = 1'b0;
    checkOutput("rst_hold_out", out_vec, 64'd0);
    checkOutput("rst_hold_valid", 64'(out_valid), 64'd0);
    checkOutput("rst_hold_busy", 64'(busy), 64'd0);
    #1;
    checkOutput("rst_hold_in_ready", 64'(in_ready), 64'd1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
